// File: rtl/mips_io_port_if.sv
// Bus bundle between the MIPS core / external stream and the I/O port peripheral.
// The master side drives the core strobes and the external stream inputs; the slave
// side is the peripheral itself.
interface mips_io_port_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [DATA_W-1:0] cpu_data_out;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_data_in;
    logic              interrupt;
    logic              intr_ack;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [ADDR_W:0]   rx_count;
    logic              tx_overflow;

    modport master (
        output cpu_data_out, cpu_wr, cpu_rd, intr_ack,
               ext_in_data, ext_in_valid, ext_out_ready,
        input  cpu_data_in, interrupt, ext_in_ready,
               ext_out_data, ext_out_valid, rx_count, tx_overflow
    );

    modport slave (
        input  cpu_data_out, cpu_wr, cpu_rd, intr_ack,
               ext_in_data, ext_in_valid, ext_out_ready,
        output cpu_data_in, interrupt, ext_in_ready,
               ext_out_data, ext_out_valid, rx_count, tx_overflow
    );
endinterface

// File: rtl/mips_io_port.sv
// MIPS core I/O port: RX FIFO (external stream -> core), TX FIFO (core -> external
// stream) and a three-state interrupt controller driven by RX occupancy.
module mips_io_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int THRESH = 1
) (
    input  logic         clk,
    input  logic         reset,
    mips_io_port_if.slave bus
);

    localparam logic [ADDR_W:0]   CNT_FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_THRESH = (ADDR_W+1)'(THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // ---------------- RX FIFO storage and control ----------------
    logic [DATA_W-1:0] rx_mem_q [DEPTH];
    logic [ADDR_W-1:0] rx_wptr_q, rx_wptr_d;
    logic [ADDR_W-1:0] rx_rptr_q, rx_rptr_d;
    logic [ADDR_W:0]   rx_cnt_q,  rx_cnt_d;
    logic              rx_full, rx_empty, rx_push, rx_pop;

    // ---------------- TX FIFO storage and control ----------------
    logic [DATA_W-1:0] tx_mem_q [DEPTH];
    logic [ADDR_W-1:0] tx_wptr_q, tx_wptr_d;
    logic [ADDR_W-1:0] tx_rptr_q, tx_rptr_d;
    logic [ADDR_W:0]   tx_cnt_q,  tx_cnt_d;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic              tx_ovf_q,  tx_ovf_d;

    irq_state_e        state_q, state_d;

    // Handshake qualification; full/empty come from registered counts only, so a pop
    // never frees space for a push in the same cycle.
    always_comb begin
        rx_full  = (rx_cnt_q == CNT_FULL);
        rx_empty = (rx_cnt_q == '0);
        tx_full  = (tx_cnt_q == CNT_FULL);
        tx_empty = (tx_cnt_q == '0);
        rx_push  = bus.ext_in_valid & ~rx_full;
        rx_pop   = bus.cpu_rd & ~rx_empty;
        tx_push  = bus.cpu_wr & ~tx_full;
        tx_pop   = ~tx_empty & bus.ext_out_ready;
    end

    // Next pointer/count values for both FIFOs plus the sticky overflow flag.
    always_comb begin
        rx_wptr_d = rx_push ? rx_wptr_q + PTR_ONE : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + PTR_ONE : rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else if (!rx_push && rx_pop) begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end

        tx_wptr_d = tx_push ? tx_wptr_q + PTR_ONE : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + PTR_ONE : tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CNT_ONE;
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - CNT_ONE;
        end

        tx_ovf_d = tx_ovf_q | (bus.cpu_wr & tx_full);
    end

    // FIFO pointer, count and overflow registers; reset discards all buffered data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
        end
    end

    // FIFO data storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= bus.ext_in_data;
        end
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= bus.cpu_data_out;
        end
    end

    // Interrupt state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Interrupt next-state: raise on occupancy, wait for ack, then wait for drain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (rx_cnt_q >= CNT_THRESH) state_d = ST_ASSERT;
            ST_ASSERT:  if (bus.intr_ack)           state_d = ST_SERVICE;
            ST_SERVICE: if (rx_cnt_q == '0)         state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // Outputs: interrupt decodes straight from the state register, data heads fall through.
    always_comb begin
        bus.interrupt     = (state_q == ST_ASSERT);
        bus.cpu_data_in   = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
        bus.ext_in_ready  = ~rx_full;
        bus.ext_out_data  = tx_mem_q[tx_rptr_q];
        bus.ext_out_valid = ~tx_empty;
        bus.rx_count      = rx_cnt_q;
        bus.tx_overflow   = tx_ovf_q;
    end

endmodule

// File: tb/tb_mips_io_port.sv
// Self-checking bench for mips_io_port: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model.
module tb_mips_io_port;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int THRESH = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mips_io_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mips_io_port #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .THRESH(THRESH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: two queues, a sticky overflow bit, and interrupt bookkeeping
    // (irq pending, and "acknowledged, waiting for RX to drain").
    logic [DATA_W-1:0] rxq[$];
    logic [DATA_W-1:0] txq[$];
    bit m_ovf, m_irq, m_drain;

    function automatic logic [DATA_W-1:0] exp_data_in();
        return (rxq.size() > 0) ? rxq[0] : '0;
    endfunction

    task automatic model_clear();
        rxq.delete();
        txq.delete();
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        m_drain = 1'b0;
    endtask

    task automatic drive_idle();
        bus.cpu_data_out  = '0;
        bus.cpu_wr        = 1'b0;
        bus.cpu_rd        = 1'b0;
        bus.intr_ack      = 1'b0;
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = 1'b0;
        bus.ext_out_ready = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        int rc, tc;
        @(posedge clk);
        if (reset) begin
            rc = rxq.size();
            tc = txq.size();
            if (!m_irq && !m_drain) begin
                if (rc >= THRESH) m_irq = 1'b1;
            end else if (m_irq) begin
                if (bus.intr_ack) begin m_irq = 1'b0; m_drain = 1'b1; end
            end else begin
                if (rc == 0) m_drain = 1'b0;
            end
            if (bus.cpu_wr && tc == DEPTH) m_ovf = 1'b1;
            if (bus.cpu_rd && rc > 0) void'(rxq.pop_front());
            if (bus.ext_in_valid && rc < DEPTH) rxq.push_back(bus.ext_in_data);
            if (bus.ext_out_ready && tc > 0) void'(txq.pop_front());
            if (bus.cpu_wr && tc < DEPTH) txq.push_back(bus.cpu_data_out);
        end
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL rst_rx_count got %0d exp 0", bus.rx_count); end
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL rst_interrupt got %0b exp 0", bus.interrupt); end
        checks++; if (bus.ext_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %0b exp 0", bus.ext_out_valid); end
        checks++; if (bus.cpu_data_in !== 16'h0) begin failures++; $display("FAIL rst_data_in got %h exp 0000", bus.cpu_data_in); end
        checks++; if (bus.tx_overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got %0b exp 0", bus.tx_overflow); end
        checks++; if (bus.ext_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %0b exp 1", bus.ext_in_ready); end
        reset = 1'b1;
        tick();
        // Preload 2 RX words and 3 TX words, then let the interrupt rise.
        for (int i = 0; i < 3; i++) begin
            bus.ext_in_valid = (i < 2);
            bus.ext_in_data  = 16'($urandom);
            bus.cpu_wr       = 1'b1;
            bus.cpu_data_out = 16'($urandom);
            tick();
        end
        drive_idle();
        tick();
        checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL pre_rst_interrupt got %0b exp 1", bus.interrupt); end
        checks++; if (bus.rx_count !== 3'd2) begin failures++; $display("FAIL pre_rst_rx_count got %0d exp 2", bus.rx_count); end
        checks++; if (bus.cpu_data_in !== rxq[0]) begin failures++; $display("FAIL pre_rst_data_in got %h exp %h", bus.cpu_data_in, rxq[0]); end
        // Mid-cycle asynchronous reset.
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL async_rx_count got %0d exp 0", bus.rx_count); end
        checks++; if (bus.ext_out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid got %0b exp 0", bus.ext_out_valid); end
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL async_interrupt got %0b exp 0", bus.interrupt); end
        checks++; if (bus.cpu_data_in !== 16'h0) begin failures++; $display("FAIL async_data_in got %h exp 0000", bus.cpu_data_in); end
        tick();
        // Pushes while held in reset are ignored.
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h5555;
        tick();
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL in_reset_push got %0d exp 0", bus.rx_count); end
        drive_idle();
        reset = 1'b1;
        tick();
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL post_rst_rx_count got %0d exp 0", bus.rx_count); end
    endtask

    task automatic test_rx_irq();
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h1234;
        tick();
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL irq_early got %0b exp 0", bus.interrupt); end
        checks++; if (bus.cpu_data_in !== 16'h1234) begin failures++; $display("FAIL rx_head1 got %h exp 1234", bus.cpu_data_in); end
        bus.ext_in_data = 16'hABCD;
        tick();
        bus.ext_in_valid = 1'b0;
        checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL irq_latency got %0b exp 1", bus.interrupt); end
        checks++; if (bus.rx_count !== 3'd2) begin failures++; $display("FAIL rx_count2 got %0d exp 2", bus.rx_count); end
        checks++; if (bus.cpu_data_in !== 16'h1234) begin failures++; $display("FAIL rx_head_hold got %h exp 1234", bus.cpu_data_in); end
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL irq_ack got %0b exp 0", bus.interrupt); end
        bus.cpu_rd = 1'b1;
        tick();
        checks++; if (bus.cpu_data_in !== 16'hABCD) begin failures++; $display("FAIL rx_head2 got %h exp abcd", bus.cpu_data_in); end
        tick();
        checks++; if (bus.cpu_data_in !== 16'h0000) begin failures++; $display("FAIL rx_empty_data got %h exp 0000", bus.cpu_data_in); end
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL rx_drained got %0d exp 0", bus.rx_count); end
        // Read on empty is ignored.
        tick();
        bus.cpu_rd = 1'b0;
        checks++; if (bus.rx_count !== 3'd0) begin failures++; $display("FAIL rd_empty got %0d exp 0", bus.rx_count); end
        tick();
        checks++; if (bus.interrupt !== m_irq) begin failures++; $display("FAIL irq_idle got %0b exp %0b", bus.interrupt, m_irq); end
    endtask

    task automatic test_rx_full();
        logic [DATA_W-1:0] w [5];
        logic [DATA_W-1:0] base;
        base = 16'($urandom);
        for (int k = 0; k < 5; k++) w[k] = base + 16'(k + 1);
        bus.ext_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.ext_in_data = w[k];
            tick();
        end
        bus.ext_in_data = w[4];
        checks++; if (bus.ext_in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got %0b exp 0", bus.ext_in_ready); end
        checks++; if (bus.rx_count !== 3'd4) begin failures++; $display("FAIL full_count got %0d exp 4", bus.rx_count); end
        tick();
        checks++; if (bus.rx_count !== 3'd4) begin failures++; $display("FAIL full_held got %0d exp 4", bus.rx_count); end
        bus.cpu_rd = 1'b1;
        #1;
        checks++; if (bus.ext_in_ready !== 1'b0) begin failures++; $display("FAIL full_rd_ready got %0b exp 0", bus.ext_in_ready); end
        tick();
        bus.cpu_rd = 1'b0;
        checks++; if (bus.rx_count !== 3'd3) begin failures++; $display("FAIL no_pushthru got %0d exp 3", bus.rx_count); end
        checks++; if (bus.ext_in_ready !== 1'b1) begin failures++; $display("FAIL ready_rise got %0b exp 1", bus.ext_in_ready); end
        tick();
        bus.ext_in_valid = 1'b0;
        checks++; if (bus.rx_count !== 3'd4) begin failures++; $display("FAIL fifth_accept got %0d exp 4", bus.rx_count); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (bus.cpu_data_in !== w[k]) begin failures++; $display("FAIL full_order%0d got %h exp %h", k, bus.cpu_data_in, w[k]); end
            bus.cpu_rd = 1'b1;
            tick();
            bus.cpu_rd = 1'b0;
        end
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        tick();
        tick();
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL full_irq_done got %0b exp 0", bus.interrupt); end
    endtask

    task automatic test_tx_overflow();
        bus.ext_out_ready = 1'b0;
        bus.cpu_wr = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus.cpu_data_out = 16'(k);
            tick();
        end
        bus.cpu_wr = 1'b0;
        checks++; if (bus.tx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got %0b exp 1", bus.tx_overflow); end
        checks++; if (bus.ext_out_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got %0b exp 1", bus.ext_out_valid); end
        tick();
        checks++; if (bus.ext_out_data !== 16'h0001) begin failures++; $display("FAIL ovf_stable got %h exp 0001", bus.ext_out_data); end
        // Write coinciding with a pop while full is still dropped.
        bus.ext_out_ready = 1'b1;
        bus.cpu_wr        = 1'b1;
        bus.cpu_data_out  = 16'h0099;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== 16'(k)) begin
                failures++; $display("FAIL tx_order%0d got v=%0b d=%h exp v=1 d=%h", k, bus.ext_out_valid, bus.ext_out_data, 16'(k)); end
            tick();
            bus.cpu_wr = 1'b0;
        end
        checks++; if (bus.ext_out_valid !== 1'b0) begin failures++; $display("FAIL tx_drained got %0b exp 0", bus.ext_out_valid); end
        checks++; if (bus.tx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %0b exp 1", bus.tx_overflow); end
        bus.ext_out_ready = 1'b0;
    endtask

    task automatic test_wrap_simul();
        logic [DATA_W-1:0] base;
        base = 16'($urandom);
        bus.cpu_wr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.cpu_data_out = base + 16'(k);
            tick();
        end
        bus.ext_out_ready = 1'b1;
        for (int k = 2; k < 10; k++) begin
            bus.cpu_data_out = base + 16'(k);
            checks++; if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== base + 16'(k - 2)) begin
                failures++; $display("FAIL wrap_word%0d got v=%0b d=%h exp v=1 d=%h", k - 2, bus.ext_out_valid, bus.ext_out_data, base + 16'(k - 2)); end
            tick();
        end
        bus.cpu_wr = 1'b0;
        for (int k = 8; k < 10; k++) begin
            checks++; if (bus.ext_out_data !== base + 16'(k)) begin failures++; $display("FAIL wrap_tail%0d got %h exp %h", k, bus.ext_out_data, base + 16'(k)); end
            tick();
        end
        checks++; if (bus.ext_out_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got %0b exp 0", bus.ext_out_valid); end
        bus.ext_out_ready = 1'b0;
    endtask

    task automatic test_rearm();
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'($urandom);
        tick();
        bus.ext_in_valid = 1'b0;
        tick();
        checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL rearm_first got %0b exp 1", bus.interrupt); end
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        bus.ext_in_valid = 1'b1;
        repeat (2) begin bus.ext_in_data = 16'($urandom); tick(); end
        bus.ext_in_valid = 1'b0;
        repeat (2) tick();
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL service_no_irq got %0b exp 0", bus.interrupt); end
        checks++; if (bus.rx_count !== 3'd3) begin failures++; $display("FAIL service_count got %0d exp 3", bus.rx_count); end
        bus.cpu_rd = 1'b1;
        repeat (3) tick();
        bus.cpu_rd = 1'b0;
        tick();
        bus.ext_in_valid = 1'b1;
        tick();
        bus.ext_in_valid = 1'b0;
        checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL rearm_latency got %0b exp 0", bus.interrupt); end
        tick();
        checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL rearm_irq got %0b exp 1", bus.interrupt); end
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.ext_in_valid  = ($urandom_range(0, 99) < 55);
            bus.ext_in_data   = 16'($urandom);
            bus.cpu_rd        = ($urandom_range(0, 99) < 45);
            bus.cpu_wr        = ($urandom_range(0, 99) < 50);
            bus.cpu_data_out  = 16'($urandom);
            bus.ext_out_ready = ($urandom_range(0, 99) < 45);
            bus.intr_ack      = ($urandom_range(0, 99) < 20);
            tick();
            checks++; if (bus.rx_count !== 3'(rxq.size())) begin failures++; $display("FAIL rnd_rx_count c=%0d got %0d exp %0d", c, bus.rx_count, rxq.size()); end
            checks++; if (bus.cpu_data_in !== exp_data_in()) begin failures++; $display("FAIL rnd_data_in c=%0d got %h exp %h", c, bus.cpu_data_in, exp_data_in()); end
            checks++; if (bus.ext_in_ready !== (rxq.size() < DEPTH)) begin failures++; $display("FAIL rnd_in_ready c=%0d got %0b", c, bus.ext_in_ready); end
            checks++; if (bus.ext_out_valid !== (txq.size() > 0)) begin failures++; $display("FAIL rnd_out_valid c=%0d got %0b exp %0b", c, bus.ext_out_valid, txq.size() > 0); end
            if (txq.size() > 0) begin
                checks++; if (bus.ext_out_data !== txq[0]) begin failures++; $display("FAIL rnd_out_data c=%0d got %h exp %h", c, bus.ext_out_data, txq[0]); end
            end
            checks++; if (bus.interrupt !== m_irq) begin failures++; $display("FAIL rnd_interrupt c=%0d got %0b exp %0b", c, bus.interrupt, m_irq); end
            checks++; if (bus.tx_overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow c=%0d got %0b exp %0b", c, bus.tx_overflow, m_ovf); end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_rx_irq();
        test_rx_full();
        test_tx_overflow();
        test_wrap_simul();
        test_rearm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
